// File: rtl/pulse_event_buffer_pkg.sv
// rtl/pulse_event_buffer_pkg.sv - shared limits and counter-operation decode for the pulse event buffer
package pulse_event_buffer_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int CNT_W_MIN       = 1;
  localparam int CNT_W_MAX       = 8;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC,
    CNT_SAT
  } cnt_op_e;

  // An arrival and an accept on the same edge cancel, even when saturated.
  function automatic cnt_op_e cnt_op(input logic arrive, input logic accept, input logic saturated);
    if (arrive && !accept) return saturated ? CNT_SAT : CNT_INC;
    if (!arrive && accept) return CNT_DEC;
    return CNT_HOLD;
  endfunction

endpackage

// File: rtl/pulse_event_buffer_sync.sv
// rtl/pulse_event_buffer_sync.sv - level synchronizer chain with toggle-to-pulse arrival detect
module toggle_sync_detect
  import pulse_event_buffer_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic level_in,
  output logic arrive
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync_stages
    $error("toggle_sync_detect: SYNC_STAGES out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;

  // Pure shift: nothing but wires between the synchronizer flops.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], level_in};
    level_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
    end
  end

  assign arrive = sync_q[SYNC_STAGES-1] ^ level_q;

endmodule

// File: rtl/pulse_event_buffer.sv
// rtl/pulse_event_buffer.sv - counts toggle events from another clock domain and hands them out by valid/ready
module pulse_event_buffer
  import pulse_event_buffer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             level_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_count,
  output logic             ovf,
  input  logic             ovf_clr
);

  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("pulse_event_buffer: CNT_W out of range");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             arrive;
  logic             accept;
  logic             saturated;
  cnt_op_e          op;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  toggle_sync_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .level_in(level_in),
    .arrive  (arrive)
  );

  assign evt_valid = (cnt_q != '0);
  assign evt_count = cnt_q;
  assign ovf       = ovf_q;

  always_comb begin
    accept    = evt_valid & evt_ready;
    saturated = (cnt_q == CNT_MAX);
    op        = cnt_op(arrive, accept, saturated);
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    case (op)
      CNT_INC: cnt_d = cnt_q + CNT_W'(1);
      CNT_DEC: cnt_d = cnt_q - CNT_W'(1);
      CNT_SAT: ovf_d = 1'b1;
      default: ;
    endcase
    // A new overflow beats a clear on the same edge.
    if (op != CNT_SAT && ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pulse_event_buffer.sv
// tb/tb_pulse_event_buffer.sv - self-checking bench for pulse_event_buffer against an event-schedule model
module tb_pulse_event_buffer;

  localparam int SS   = 2;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          level_in = 1'b0;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [CW-1:0] evt_count;
  logic          ovf;
  logic          ovf_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  pulse_event_buffer #(
    .SYNC_STAGES(SS),
    .CNT_W      (CW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .level_in (level_in),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_count(evt_count),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference: a level change first seen on edge e is counted on edge e+SS.
  int m_count;
  bit m_ovf;
  bit m_seen;
  int m_edge;
  int m_q[$];
  bit m_arr, m_acc, m_set;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_count = 0;
      m_ovf   = 1'b0;
      m_seen  = 1'b0;
      m_edge  = 0;
      m_q.delete();
    end else begin
      m_edge = m_edge + 1;
      m_arr  = 1'b0;
      if (m_q.size() > 0 && m_q[0] == m_edge) begin
        m_arr = 1'b1;
        void'(m_q.pop_front());
      end
      m_acc = (m_count != 0) && evt_ready;
      m_set = m_arr && !m_acc && (m_count == MAXC);
      if (m_arr && !m_acc && m_count < MAXC) m_count = m_count + 1;
      else if (!m_arr && m_acc) m_count = m_count - 1;
      if (m_set) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (level_in != m_seen) begin
        m_q.push_back(m_edge + SS);
        m_seen = level_in;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    level_in  = 1'b0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    level_in = 1'b0;
    #1;
    checks++;
    if (evt_count !== '0 || evt_valid !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d valid=%b ovf=%b, want 0/0/0", evt_count, evt_valid, ovf);
    end
    @(negedge clk);
    reset_n   = 1'b1;
    evt_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (evt_count !== '0 || evt_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_release_idle: cycle %0d count=%0d valid=%b, want 0/0", i, evt_count, evt_valid);
      end
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_single_event();
    do_reset();
    level_in = 1'b1;
    tick();
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: valid=%b after %0d edges, want 0", evt_valid, SS);
    end
    tick();
    checks++;
    if (evt_count !== CW'(1) || evt_valid !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL single_event: count=%0d valid=%b ovf=%b, want 1/1/0", evt_count, evt_valid, ovf);
    end
  endtask

  task automatic test_drain();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      level_in = ~level_in;
      repeat (4) tick();
    end
    checks++;
    if (evt_count !== CW'(3)) begin
      errors++;
      $display("FAIL drain_fill: count=%0d, want 3", evt_count);
    end
    evt_ready = 1'b1;
    for (int exp = 2; exp >= 0; exp--) begin
      tick();
      checks++;
      if (evt_count !== CW'(exp)) begin
        errors++;
        $display("FAIL drain_step: count=%0d, want %0d", evt_count, exp);
      end
    end
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_valid: valid=%b, want 0", evt_valid);
    end
    tick();
    checks++;
    if (evt_count !== '0) begin
      errors++;
      $display("FAIL no_underflow: count=%0d, want 0", evt_count);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    repeat (2) begin
      level_in = ~level_in;
      repeat (4) tick();
    end
    level_in = ~level_in;
    repeat (SS) tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++;
    if (evt_count !== CW'(2) || evt_count !== CW'(m_count)) begin
      errors++;
      $display("FAIL simultaneous: count=%0d, want 2 (model %0d)", evt_count, m_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (4) begin
      level_in = ~level_in;
      repeat (4) tick();
    end
    checks++;
    if (evt_count !== CW'(MAXC) || ovf !== 1'b1) begin
      errors++;
      $display("FAIL saturate: count=%0d ovf=%b, want %0d/1", evt_count, ovf, MAXC);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (evt_count !== CW'(MAXC) || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: count=%0d ovf=%b, want %0d/0", evt_count, ovf, MAXC);
    end
    level_in = ~level_in;
    repeat (SS) tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins: ovf=%b, want 1", ovf);
    end
    level_in = ~level_in;
    repeat (SS) tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++;
    if (evt_count !== CW'(MAXC)) begin
      errors++;
      $display("FAIL sat_simultaneous: count=%0d, want %0d", evt_count, MAXC);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (3) begin
      level_in = ~level_in;
      repeat (4) tick();
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++;
    if (evt_count !== CW'(2) || level_in !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_setup: count=%0d level=%b, want 2/1", evt_count, level_in);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (evt_count !== '0 || ovf !== 1'b0 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear: count=%0d ovf=%b valid=%b, want 0/0/0", evt_count, ovf, evt_valid);
    end
    @(negedge clk);
    tick();
    reset_n = 1'b1;
    repeat (SS + 1) tick();
    checks++;
    if (evt_count !== CW'(1)) begin
      errors++;
      $display("FAIL reset_mid_event: count=%0d, want 1", evt_count);
    end
    repeat (6) tick();
    checks++;
    if (evt_count !== CW'(1) || evt_count !== CW'(m_count)) begin
      errors++;
      $display("FAIL reset_mid_single: count=%0d, want 1 (model %0d)", evt_count, m_count);
    end
  endtask

  task automatic test_random();
    int hold;
    do_reset();
    hold = SS + 1;
    for (int i = 0; i < 600; i++) begin
      if (hold >= SS + 1 && $urandom_range(0, 2) == 0) begin
        level_in = ~level_in;
        hold = 0;
      end
      evt_ready = ($urandom_range(0, 4) == 0);
      ovf_clr   = ($urandom_range(0, 9) == 0);
      tick();
      hold++;
      checks++;
      if (evt_count !== CW'(m_count) || evt_valid !== (m_count != 0) || ovf !== m_ovf) begin
        errors++;
        $display("FAIL random_cycle %0d: count=%0d valid=%b ovf=%b, want %0d/%b/%b",
                 i, evt_count, evt_valid, ovf, m_count, (m_count != 0), m_ovf);
      end
    end
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_drain();
    test_simultaneous();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_event_buffer.md
PULSE_EVENT_BUFFER -- requirements
Module: pulse_event_buffer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on level_in (legal range 2..4).
REQ-002 SHALL have parameter CNT_W, default 4, width of the pending-event counter (legal range 1..8).
REQ-003 SHALL have port clk  input  1  sole clock; destination-domain clock; all flops on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port level_in  input  1  toggle level from the source-domain pulse sender; asynchronous to clk; each transition is one event.
REQ-006 SHALL have port evt_valid  output  1  at least one event is pending.
REQ-007 SHALL have port evt_ready  input  1  consumer accepts one event when high together with evt_valid.
REQ-008 SHALL have port evt_count  output  CNT_W  number of pending events.
REQ-009 SHALL have port ovf  output  1  sticky flag: an event arrived while the counter was saturated.
REQ-010 SHALL have port ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-011 SHALL pass level_in through a SYNC_STAGES-deep flop chain; no logic between those flops.
REQ-012 SHALL register the last synchronizer output into level_q and form arrive = sync_last XOR level_q, one cycle wide per transition.
REQ-013 SHALL increment evt_count on the edge after arrive is high, so evt_valid rises SYNC_STAGES+1 edges after the first edge that samples the new level_in.
REQ-014 SHALL drive evt_valid = (evt_count != 0), combinationally from the counter register.
REQ-015 SHALL define accept = evt_valid AND evt_ready; accept decrements evt_count by 1 on that edge.
REQ-016 SHALL ignore evt_ready while evt_valid is low (no underflow, count stays 0).
REQ-017 SHALL leave evt_count unchanged when arrive and accept occur in the same cycle, including at saturation.
REQ-018 SHALL saturate evt_count at 2^CNT_W-1; arrive without accept at saturation leaves count unchanged and sets ovf on the same edge.
REQ-019 SHALL clear ovf on an edge with ovf_clr high; if the same edge also sets ovf, set wins.
REQ-020 SHALL treat back-to-back transitions of level_in as separate events, provided each level is held at least SYNC_STAGES+1 clk cycles; shorter spacing is a source-side constraint, not detected here.

Reset
REQ-021 SHALL asynchronously clear all synchronizer flops, level_q, evt_count and ovf to 0 while reset_n is low; outputs evt_valid=0, evt_count=0, ovf=0.
REQ-022 SHALL release reset on the clk edge after reset_n deasserts, with no spurious event if level_in is 0 (source sender resets level to 0).
REQ-023 SHALL discard pending events and the sticky flag on reset mid-operation; a level_in of 1 at release produces exactly one event.

Structure
REQ-024 SHALL instantiate one sub-module toggle_sync_detect (synchronizer chain + level_q + arrive output), parameterised by SYNC_STAGES.
REQ-025 SHALL keep counter/handshake/ovf logic in pulse_event_buffer; no shared package required; the legal-range limits for SYNC_STAGES and CNT_W are checked by elaboration-time assertions.

Verification
REQ-026 SHALL cover single event: SYNC_STAGES=2, evt_ready=0, toggle level_in 0->1 -> evt_valid=1 and evt_count=1 after 3 edges, ovf=0.
REQ-027 SHALL cover drain: 3 events spaced 4 cycles, then evt_ready=1 -> count 3,2,1,0 on consecutive edges; evt_valid low after third accept.
REQ-028 SHALL cover simultaneous: count=2, arrive and accept in same cycle -> count stays 2.
REQ-029 SHALL cover saturation: CNT_W=2, 4 events with evt_ready=0 -> count=3, ovf=1; ovf_clr pulse -> ovf=0, count=3.
REQ-030 SHALL cover reset mid-operation: count=2, level_in=1, assert reset_n low -> count=0, ovf=0 immediately; release -> exactly one event, count=1.
